imem_arbiter: RTL

//  Shares one single-port synchronous program memory between two requesters:
//  - the CPU fetch port;
//  - a boot/debug loader port, which reads and writes instructions.

---
 rtl/imem_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// Purpose: shares one single-port program memory between CPU fetch and a boot/debug loader (BOOT then RUN phase).
// Latency: grants are combinational; read data returns 1 cycle after grant; a new grant is possible every cycle.
// Backpressure: requesters hold until gnt; fetch wins in RUN except after STARVE_MAX denials. Option: IMEM_ARB_RANGE_CHECK_EN.
module imem_arbiter #(
    parameter int DEPTH_W    = 7,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               boot_done,
    input  logic               fetch_req,
    input  logic [31:0]        fetch_addr,
    output logic               fetch_gnt,
    output logic               fetch_rvalid,
    output logic [31:0]        fetch_rdata,
    output logic               cpu_stall,
    input  logic               ld_req,
    input  logic               ld_we,
    input  logic [31:0]        ld_addr,
    input  logic [31:0]        ld_wdata,
    output logic               ld_gnt,
    output logic               ld_rvalid,
    output logic [31:0]        ld_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [DEPTH_W-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);
    localparam logic [31:0] NOP_WORD = 32'hE1A00000;

    typedef enum logic {BOOT, RUN} state_t;

    state_t     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       ld_force;
    logic       fetch_oor, ld_oor;
    logic       fetch_rv_q, ld_rv_q;
    logic       fetch_oor_q, ld_oor_q;

`ifdef IMEM_ARB_RANGE_CHECK_EN
    assign fetch_oor = |fetch_addr[31:DEPTH_W+2];
    assign ld_oor    = |ld_addr[31:DEPTH_W+2];
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_addr[1:0], ld_addr[1:0]};
`else
    // Upper bits alias: the array wraps modulo its word count.
    assign fetch_oor = 1'b0;
    assign ld_oor    = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_addr[31:DEPTH_W+2], fetch_addr[1:0],
                                ld_addr[31:DEPTH_W+2], ld_addr[1:0]};
`endif

    assign ld_force = fetch_req && ld_req && (starve_q == STARVE_MAX[3:0]);

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        fetch_gnt = 1'b0;
        ld_gnt    = 1'b0;
        case (state_q)
            BOOT: begin
                ld_gnt = ld_req;
                if (boot_done) state_d = RUN;
            end
            RUN: begin
                if (ld_force) begin
                    ld_gnt = 1'b1;
                end else begin
                    fetch_gnt = fetch_req;
                    ld_gnt    = ld_req && !fetch_req;
                end
                if (!ld_req || ld_gnt)
                    starve_d = 4'd0;
                else if (starve_q != STARVE_MAX[3:0])
                    starve_d = starve_q + 4'd1;
            end
            default: state_d = BOOT;
        endcase
    end

    assign cpu_stall = fetch_req && !fetch_gnt;

    // Out-of-range accesses are still granted, only the array access is suppressed.
    assign mem_en    = (fetch_gnt && !fetch_oor) || (ld_gnt && !ld_oor);
    assign mem_we    = ld_gnt && ld_we && !ld_oor;
    assign mem_addr  = fetch_gnt ? fetch_addr[DEPTH_W+1:2] : ld_addr[DEPTH_W+1:2];
    assign mem_wdata = ld_gnt ? ld_wdata : 32'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= BOOT;
            starve_q    <= 4'd0;
            fetch_rv_q  <= 1'b0;
            ld_rv_q     <= 1'b0;
            fetch_oor_q <= 1'b0;
            ld_oor_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            fetch_rv_q  <= fetch_gnt;
            ld_rv_q     <= ld_gnt && !ld_we;
            fetch_oor_q <= fetch_oor;
            ld_oor_q    <= ld_oor;
        end
    end

    assign fetch_rvalid = fetch_rv_q;
    assign ld_rvalid    = ld_rv_q;
    assign fetch_rdata  = !fetch_rv_q ? 32'h0 : (fetch_oor_q ? NOP_WORD : mem_rdata);
    assign ld_rdata     = (!ld_rv_q || ld_oor_q) ? 32'h0 : mem_rdata;

endmodule
